// File: rtl/truth_table_scanner_if.sv
// Handshake and result bundle between a scan controller and the truth-table scanner.
// The scanner takes the slave view; the function block and its controller take the master view.
interface truth_table_scanner_if;
  logic       start;
  logic [7:0] expected;
  logic       f;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       mismatch;
  logic [2:0] first_fail_idx;

  modport master (
    output start, expected, f,
    input  a, b, c, busy, done, table_out, mismatch, first_fail_idx
  );

  modport slave (
    input  start, expected, f,
    output a, b, c, busy, done, table_out, mismatch, first_fail_idx
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps {a,b,c} through 0..7, samples f after a settle time per vector and
// checks the captured truth table against an expected table latched at start.
module truth_table_scanner #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_scanner_if.slave bus
);
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned TBL_W = 8;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [TBL_W-1:0]   exp_q, exp_n;
  logic [TBL_W-1:0]   tbl_q, tbl_n;
  logic               mis_q, mis_n;
  logic [IDX_W-1:0]   ffi_q, ffi_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [IDX_W-1:0]   abc_q, abc_n;
  logic [TBL_W-1:0]   diff;
  logic               sample;

  assign sample = (state == SCAN) && (cnt == CNT_W'(SETTLE_CYCLES - 1));

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      exp_q  <= '0;
      tbl_q  <= '0;
      mis_q  <= 1'b0;
      ffi_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      abc_q  <= '0;
    end else begin
      state  <= state_next;
      idx    <= idx_n;
      cnt    <= cnt_n;
      exp_q  <= exp_n;
      tbl_q  <= tbl_n;
      mis_q  <= mis_n;
      ffi_q  <= ffi_n;
      busy_q <= busy_n;
      done_q <= done_n;
      abc_q  <= abc_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SCAN;
      SCAN:    if (sample && (idx == IDX_W'(7))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs
  always_comb begin
    idx_n = idx;
    cnt_n = cnt;
    exp_n = exp_q;
    tbl_n = tbl_q;
    mis_n = mis_q;
    ffi_n = ffi_q;
    diff  = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          exp_n = bus.expected;
          tbl_n = '0;
          mis_n = 1'b0;
          ffi_n = '0;
          idx_n = '0;
          cnt_n = '0;
        end
      end
      SCAN: begin
        if (sample) begin
          tbl_n[idx] = bus.f;
          cnt_n      = '0;
          if (idx != IDX_W'(7)) begin
            idx_n = idx + IDX_W'(1);
          end else begin
            // Table is complete on this edge; lowest differing vector wins
            diff  = tbl_n ^ exp_q;
            mis_n = |diff;
            ffi_n = '0;
            for (int k = TBL_W - 1; k >= 0; k--) begin
              if (diff[k]) ffi_n = IDX_W'(k);
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
    busy_n = (state_next == SCAN);
    done_n = (state_next == DONE);
    abc_n  = (state_next == SCAN) ? idx_n : '0;
  end

  assign bus.a              = abc_q[2];
  assign bus.b              = abc_q[1];
  assign bus.c              = abc_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.table_out      = tbl_q;
  assign bus.mismatch       = mis_q;
  assign bus.first_fail_idx = ffi_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: unit 0 runs with SETTLE_CYCLES=1, unit 1 with 3.
// Directed table, hand-written reset sequence and random tables against a reference model.
module tb_truth_table_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  truth_table_scanner_if if0 ();
  truth_table_scanner_if if1 ();

  truth_table_scanner #(.SETTLE_CYCLES(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  truth_table_scanner #(.SETTLE_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic       start_v  [2];
  logic [7:0] exp_v    [2];
  logic       use_expr [2];
  logic [7:0] ftbl     [2];
  logic [2:0] abc_v    [2];
  logic       busy_v   [2];
  logic       done_v   [2];
  logic [7:0] tbl_v    [2];
  logic       mis_v    [2];
  logic [2:0] ffi_v    [2];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic f_expr(input logic a, input logic b, input logic c);
    return (~b & ~c) | (~a & b) | (a & c);
  endfunction

  assign if0.start    = start_v[0];
  assign if1.start    = start_v[1];
  assign if0.expected = exp_v[0];
  assign if1.expected = exp_v[1];
  assign if0.f = use_expr[0] ? f_expr(if0.a, if0.b, if0.c) : ftbl[0][{if0.a, if0.b, if0.c}];
  assign if1.f = use_expr[1] ? f_expr(if1.a, if1.b, if1.c) : ftbl[1][{if1.a, if1.b, if1.c}];

  assign abc_v[0]  = {if0.a, if0.b, if0.c};
  assign abc_v[1]  = {if1.a, if1.b, if1.c};
  assign busy_v[0] = if0.busy;
  assign busy_v[1] = if1.busy;
  assign done_v[0] = if0.done;
  assign done_v[1] = if1.done;
  assign tbl_v[0]  = if0.table_out;
  assign tbl_v[1]  = if1.table_out;
  assign mis_v[0]  = if0.mismatch;
  assign mis_v[1]  = if1.mismatch;
  assign ffi_v[0]  = if0.first_fail_idx;
  assign ffi_v[1]  = if1.first_fail_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, req);
    end
  endtask

  // Reference: the table is just f evaluated at every vector
  function automatic logic [7:0] model_tbl(input logic ex, input logic [7:0] ft);
    logic [7:0] t;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      t[k] = ex ? f_expr(v[2], v[1], v[0]) : ft[k];
    end
    return t;
  endfunction

  function automatic logic [2:0] model_ffi(input logic [7:0] t, input logic [7:0] e);
    for (int k = 0; k < 8; k++) if (t[k] != e[k]) return 3'(k);
    return 3'd0;
  endfunction

  task automatic chk_idle_zero(input int u, input string nm);
    chk({nm, "_abc"},  32'(abc_v[u]), 32'd0);
    chk({nm, "_busy"}, 32'(busy_v[u]), 32'd0);
    chk({nm, "_done"}, 32'(done_v[u]), 32'd0);
    chk({nm, "_tbl"},  32'(tbl_v[u]), 32'd0);
    chk({nm, "_mis"},  32'(mis_v[u]), 32'd0);
    chk({nm, "_ffi"},  32'(ffi_v[u]), 32'd0);
  endtask

  // One full scan; poke_vec >= 0 re-pulses start with expected=0 when that vector is on the bus
  task automatic run_scan(input int u, input logic ex, input logic [7:0] ft, input logic [7:0] e,
                          input logic [7:0] w_tbl, input logic w_mis, input logic [2:0] w_ffi,
                          input int poke_vec, input string nm);
    int  s;
    bit  poked;
    s = (u == 0) ? 1 : 3;
    poked = 1'b0;
    use_expr[u] = ex;
    ftbl[u] = ft;
    @(negedge clk);
    start_v[u] = 1'b1;
    exp_v[u] = e;
    for (int k = 1; k <= 8 * s + 1; k++) begin
      @(negedge clk);
      start_v[u] = 1'b0;
      if (k <= 8 * s) begin
        chk({nm, "_busy"}, 32'(busy_v[u]), 32'd1);
        chk({nm, "_abc"},  32'(abc_v[u]), 32'((k - 1) / s));
        chk({nm, "_nodone"}, 32'(done_v[u]), 32'd0);
        if (poke_vec >= 0 && !poked && int'(abc_v[u]) == poke_vec) begin
          start_v[u] = 1'b1;
          exp_v[u] = 8'h00;
          poked = 1'b1;
        end
      end else begin
        chk({nm, "_done"},   32'(done_v[u]), 32'd1);
        chk({nm, "_busy0"},  32'(busy_v[u]), 32'd0);
        chk({nm, "_abc0"},   32'(abc_v[u]), 32'd0);
        chk({nm, "_tbl"},    32'(tbl_v[u]), 32'(w_tbl));
        chk({nm, "_mis"},    32'(mis_v[u]), 32'(w_mis));
        chk({nm, "_ffi"},    32'(ffi_v[u]), 32'(w_ffi));
      end
    end
    @(negedge clk);
    chk({nm, "_pulse"},    32'(done_v[u]), 32'd0);
    chk({nm, "_idlebusy"}, 32'(busy_v[u]), 32'd0);
    chk({nm, "_hold_tbl"}, 32'(tbl_v[u]), 32'(w_tbl));
    chk({nm, "_hold_mis"}, 32'(mis_v[u]), 32'(w_mis));
    chk({nm, "_hold_ffi"}, 32'(ffi_v[u]), 32'(w_ffi));
  endtask

  typedef struct {
    int         u;
    logic       ex;
    logic [7:0] ft;
    logic [7:0] e;
    logic [7:0] w_tbl;
    logic       w_mis;
    logic [2:0] w_ffi;
    int         poke;
    string      nm;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 1'b1, 8'h00, 8'hBD, 8'hBD, 1'b0, 3'd0, -1, "good"};
    vecs[1] = '{0, 1'b1, 8'h00, 8'hBF, 8'hBD, 1'b1, 3'd1, -1, "badexp"};
    vecs[2] = '{0, 1'b0, 8'h00, 8'hBD, 8'h00, 1'b1, 3'd0, -1, "tie0"};
    vecs[3] = '{1, 1'b1, 8'h00, 8'hBD, 8'hBD, 1'b0, 3'd0, -1, "settle3"};
    vecs[4] = '{0, 1'b1, 8'h00, 8'hBD, 8'hBD, 1'b0, 3'd0,  3, "restart"};

    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0;
      exp_v[u] = 8'h00;
      use_expr[u] = 1'b1;
      ftbl[u] = 8'h00;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_zero(0, "rst_u0");
    chk_idle_zero(1, "rst_u1");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].u, vecs[i].ex, vecs[i].ft, vecs[i].e,
               vecs[i].w_tbl, vecs[i].w_mis, vecs[i].w_ffi, vecs[i].poke, vecs[i].nm);
    end

    // Reset in the middle of a scan, while vector 4 is driven
    begin
      bit reached;
      int dones;
      reached = 1'b0;
      dones = 0;
      use_expr[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b1;
      exp_v[0] = 8'hBD;
      for (int k = 0; k < 20 && !reached; k++) begin
        @(negedge clk);
        start_v[0] = 1'b0;
        if (abc_v[0] == 3'd4) reached = 1'b1;
      end
      chk("midrst_reach", 32'(reached), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_idle_zero(0, "midrst");
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done_v[0]) dones++;
      end
      chk("midrst_nodone", 32'(dones), 32'd0);
      run_scan(0, 1'b1, 8'h00, 8'hBD, 8'hBD, 1'b0, 3'd0, -1, "postrst");
    end

    // Random tables against the reference model
    for (int i = 0; i < 16; i++) begin
      int u;
      logic [7:0] ft, e, t;
      u = int'($urandom_range(0, 1));
      ft = 8'($urandom);
      e = ($urandom_range(0, 3) == 0) ? ft : 8'($urandom);
      t = model_tbl(1'b0, ft);
      run_scan(u, 1'b0, ft, e, t, t != e, model_ffi(t, e), -1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
